// File: rtl/mini_alu.sv
// mini_alu: single-issue processor with a 256-word instruction ROM, a 16-entry
// register file and a single-cycle ALU. One 24-bit instruction retires per clock.
// The only outputs are a registered LED byte and a write-only byte SRAM port.
//
// Instruction word: op[23:20] dst[19:16] a[15:12] b[11:8] tgt[7:0], imm16 = [15:0].
// ROM source, in priority order:
//   USE_IMAGE = 1      words come from ROM_IMAGE (word i at bits [i*24 +: 24])
//   ROM_FILE  == ""    built-in default program, unused words are NOP
//   ROM_FILE  != ""    words are bound to the named hex image by the memory
//                      initialisation step of the build; the netlist default is NOP
module mini_alu #(
   parameter int    PC_W      = 8,
   parameter int    DATA_W    = 16,
   parameter string ROM_FILE  = "",
   parameter bit    USE_IMAGE = 1'b0,
   parameter logic [24*(2**PC_W)-1:0] ROM_IMAGE = '0
) (
   input  logic        Clock,
   input  logic        Reset,
   output logic [7:0]  oLed,
   output logic [18:0] oSramAddr,
   output logic [7:0]  oSramData,
   output logic        oSramCe,
   output logic        oSramWe,
   output logic        oSramOe
);

   localparam int ROM_DEPTH = 2**PC_W;

   localparam logic [3:0] OP_STO  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_SMUL = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_BLE  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_LED  = 4'h9;
   localparam logic [3:0] OP_SRW  = 4'hA;

   // Default program: count R2 from 1 to 11, showing each value on the LEDs
   // and writing it to SRAM address == data, then park on a self-jump.
   function automatic logic [23:0] defaultWord(input int addr);
      case (addr)
         0:       defaultWord = 24'h110001;   // STO R1,1
         1:       defaultWord = 24'h120000;   // STO R2,0
         2:       defaultWord = 24'h13000A;   // STO R3,10
         3:       defaultWord = 24'h222100;   // loop: ADD R2,R2,R1
         4:       defaultWord = 24'h902000;   // LED R2
         5:       defaultWord = 24'hA02200;   // SRW R2,R2
         6:       defaultWord = 24'h702303;   // BLE R2,R3 -> loop
         7:       defaultWord = 24'h800007;   // JMP self
         default: defaultWord = 24'h000000;   // NOP
      endcase
   endfunction

   logic [23:0]        romMem [ROM_DEPTH];
   logic [PC_W-1:0]    pcReg;
   logic [PC_W-1:0]    pcNext;
   logic [23:0]        instr;
   logic [3:0]         op;
   logic [3:0]         dst;
   logic [3:0]         srcA;
   logic [3:0]         srcB;
   logic [7:0]         tgt;
   logic [15:0]        imm;
   logic [DATA_W-1:0]  rf [16];
   logic [DATA_W-1:0]  aVal;
   logic [DATA_W-1:0]  bVal;
   logic [DATA_W-1:0]  aluResult;
   logic               rfWe;
   logic [7:0]         ledReg;
   logic [18:0]        sramAddrReg;
   logic [7:0]         sramDataReg;
   logic               sramStrobeNReg;

   // ROM contents are constants, so the array folds into a lookup table that
   // is read combinationally at the current PC.
   for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : gRom
      if (USE_IMAGE) begin : gImage
         assign romMem[gi] = ROM_IMAGE[gi*24 +: 24];
      end else if (ROM_FILE == "") begin : gDefault
         assign romMem[gi] = defaultWord(gi);
      end else begin : gExternal
         assign romMem[gi] = 24'h000000;
      end
   end

   assign instr = romMem[pcReg];
   assign op    = instr[23:20];
   assign dst   = instr[19:16];
   assign srcA  = instr[15:12];
   assign srcB  = instr[11:8];
   assign tgt   = instr[7:0];
   assign imm   = instr[15:0];

   assign aVal = rf[srcA];
   assign bVal = rf[srcB];

   // Register file: every entry (R0 included) is an ordinary writable register
   // cleared by reset, so a write is visible to the very next instruction.
   for (genvar gi = 0; gi < 16; gi++) begin : gRegFile
      logic [DATA_W-1:0] valueReg;

      // Load the ALU result when the retiring instruction targets this entry.
      always_ff @(posedge Clock or negedge Reset) begin
         if (!Reset) begin
            valueReg <= '0;
         end else if (rfWe && (dst == 4'(gi))) begin
            valueReg <= aluResult;
         end
      end

      assign rf[gi] = valueReg;
   end

   // ALU result and register write enable for the current instruction.
   always_comb begin
      aluResult = '0;
      rfWe      = 1'b0;
      case (op)
         OP_STO:  begin aluResult = DATA_W'(imm);  rfWe = 1'b1; end
         OP_ADD:  begin aluResult = aVal + bVal;   rfWe = 1'b1; end
         OP_SUB:  begin aluResult = aVal - bVal;   rfWe = 1'b1; end
         // The low half of a two's-complement product does not depend on
         // operand signedness, so a DATA_W-wide multiply gives the signed result.
         OP_SMUL: begin aluResult = aVal * bVal;   rfWe = 1'b1; end
         OP_AND:  begin aluResult = aVal & bVal;   rfWe = 1'b1; end
         OP_OR:   begin aluResult = aVal | bVal;   rfWe = 1'b1; end
         default: begin aluResult = '0;            rfWe = 1'b0; end
      endcase
   end

   // Next PC: sequential with natural wrap, or the target for JMP and taken BLE.
   always_comb begin
      pcNext = pcReg + PC_W'(1);
      if ((op == OP_JMP) || ((op == OP_BLE) && (aVal <= bVal))) begin
         pcNext = PC_W'(tgt);
      end
   end

   // PC and output registers; SRAM strobes fall for exactly the cycle after
   // each SRW and stay low across back-to-back SRWs.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         pcReg          <= '0;
         ledReg         <= '0;
         sramAddrReg    <= '0;
         sramDataReg    <= '0;
         sramStrobeNReg <= 1'b1;
      end else begin
         pcReg          <= pcNext;
         sramStrobeNReg <= (op != OP_SRW);
         if (op == OP_LED) begin
            ledReg <= aVal[7:0];
         end
         if (op == OP_SRW) begin
            sramAddrReg <= 19'(aVal);
            sramDataReg <= bVal[7:0];
         end
      end
   end

   assign oLed      = ledReg;
   assign oSramAddr = sramAddrReg;
   assign oSramData = sramDataReg;
   assign oSramCe   = sramStrobeNReg;
   assign oSramWe   = sramStrobeNReg;
   assign oSramOe   = 1'b1;

endmodule

// File: tb/tb_mini_alu.sv
// tb_mini_alu: two instances of mini_alu share one clock.
//  - dutDef runs the built-in program; its LED steps and SRAM pulses are
//    checked directly against the expected 1..11 count.
//  - dut runs a bench-built image (directed arithmetic/branch cases followed by a
//    pseudo-random instruction stream) in lockstep with an instruction-level
//    reference model, with reset pulses at $urandom-chosen cycles.
module tb_mini_alu;

   typedef struct packed {
      logic [7:0]        pc;
      logic [15:0][15:0] r;
      logic [7:0]        led;
      logic [18:0]       addr;
      logic [7:0]        data;
      logic              ce;
   } mState_t;

   // Test image: directed cases at 0..21, random op/SRW pairs at 22..85,
   // JMP 0xFF at 86, NOP at 255 so the PC wraps back to 0.
   function automatic logic [24*256-1:0] buildImage();
      logic [24*256-1:0] img;
      logic [31:0]       s;
      logic [3:0]        op;
      int                pos;
      img = '0;
      img[0*24 +: 24]  = 24'h11FFFF;   // STO R1,FFFF
      img[1*24 +: 24]  = 24'h120001;   // STO R2,1
      img[2*24 +: 24]  = 24'h231200;   // ADD R3,R1,R2
      img[3*24 +: 24]  = 24'hA03300;   // SRW R3,R3
      img[4*24 +: 24]  = 24'h140000;   // STO R4,0
      img[5*24 +: 24]  = 24'h354200;   // SUB R5,R4,R2
      img[6*24 +: 24]  = 24'hA05500;   // SRW R5,R5
      img[7*24 +: 24]  = 24'h16FFFE;   // STO R6,FFFE
      img[8*24 +: 24]  = 24'h170003;   // STO R7,3
      img[9*24 +: 24]  = 24'h486700;   // SMUL R8,R6,R7
      img[10*24 +: 24] = 24'hA08800;   // SRW R8,R8
      img[11*24 +: 24] = 24'hA01200;   // SRW R1,R2 (back-to-back)
      img[12*24 +: 24] = 24'h190005;   // STO R9,5
      img[13*24 +: 24] = 24'h1A0005;   // STO R10,5
      img[14*24 +: 24] = 24'h709A10;   // BLE R9,R10 -> 16
      img[15*24 +: 24] = 24'h901000;   // LED R1 (skipped)
      img[16*24 +: 24] = 24'h909000;   // LED R9
      img[17*24 +: 24] = 24'h190006;   // STO R9,6
      img[18*24 +: 24] = 24'h709A14;   // BLE R9,R10 -> 20
      img[19*24 +: 24] = 24'h909000;   // LED R9
      img[20*24 +: 24] = 24'h701216;   // BLE R1,R2 -> 22
      img[21*24 +: 24] = 24'h902000;   // LED R2
      s   = 32'h2545F491;
      pos = 22;
      for (int k = 0; k < 32; k++) begin
         s = s ^ (s << 13);
         s = s ^ (s >> 17);
         s = s ^ (s << 5);
         case (s[31:28])
            4'd0, 4'd1, 4'd2: op = 4'h1;
            4'd3, 4'd4:       op = 4'h2;
            4'd5, 4'd6:       op = 4'h3;
            4'd7, 4'd8:       op = 4'h4;
            4'd9, 4'd12:      op = 4'h5;
            4'd10, 4'd13:     op = 4'h6;
            4'd11:            op = 4'h9;
            4'd14:            op = 4'hB;
            default:          op = 4'hF;
         endcase
         img[pos*24 +: 24]     = {op, s[19:0]};
         img[(pos+1)*24 +: 24] = {4'hA, 4'h0, s[19:16], s[3:0], 8'h00};
         pos += 2;
      end
      img[pos*24 +: 24] = 24'h8000FF;  // JMP FF
      return img;
   endfunction

   localparam logic [24*256-1:0] IMG = buildImage();

   // Instruction-level model of one retired instruction, using plain integers.
   function automatic mState_t stepModel(input mState_t s, input logic [23:0] w);
      mState_t n;
      int op, d, va, vb, sa, sb;
      n    = s;
      n.pc = s.pc + 8'd1;
      n.ce = 1'b1;
      op = int'(w[23:20]);
      d  = int'(w[19:16]);
      va = int'(s.r[w[15:12]]);
      vb = int'(s.r[w[11:8]]);
      sa = (va >= 32768) ? va - 65536 : va;
      sb = (vb >= 32768) ? vb - 65536 : vb;
      case (op)
         1:  n.r[d] = w[15:0];
         2:  n.r[d] = 16'((va + vb) % 65536);
         3:  n.r[d] = 16'((va - vb + 65536) % 65536);
         4:  n.r[d] = 16'(sa * sb);
         5:  n.r[d] = 16'(va & vb);
         6:  n.r[d] = 16'(va | vb);
         7:  if (va <= vb) n.pc = w[7:0];
         8:  n.pc = w[7:0];
         9:  n.led = 8'(va % 256);
         10: begin
            n.addr = 19'(va);
            n.data = 8'(vb % 256);
            n.ce   = 1'b0;
         end
         default: ;
      endcase
      return n;
   endfunction

   logic        clk = 1'b0;
   logic        rstN;
   logic        rstDefN;
   logic [7:0]  led, defLed;
   logic [18:0] sramAddr, defAddr;
   logic [7:0]  sramData, defData;
   logic        ce, we, oe, defCe, defWe, defOe;

   int      testsRun    = 0;
   int      testsFailed = 0;
   mState_t m;

   mini_alu #(
      .PC_W(8), .DATA_W(16), .ROM_FILE(""), .USE_IMAGE(1'b1), .ROM_IMAGE(IMG)
   ) dut (
      .Clock(clk), .Reset(rstN), .oLed(led), .oSramAddr(sramAddr),
      .oSramData(sramData), .oSramCe(ce), .oSramWe(we), .oSramOe(oe)
   );

   mini_alu dutDef (
      .Clock(clk), .Reset(rstDefN), .oLed(defLed), .oSramAddr(defAddr),
      .oSramData(defData), .oSramCe(defCe), .oSramWe(defWe), .oSramOe(defOe)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compareModel();
      checkVal("pc",        32'(dut.pcReg), 32'(m.pc));
      checkVal("led",       32'(led),       32'(m.led));
      checkVal("sram_addr", 32'(sramAddr),  32'(m.addr));
      checkVal("sram_data", 32'(sramData),  32'(m.data));
      checkVal("sram_ce",   32'(ce),        32'(m.ce));
      checkVal("sram_we",   32'(we),        32'(m.ce));
      checkVal("sram_oe",   32'(oe),        32'd1);
   endtask

   initial begin
      int          defCount;
      logic        prevDefCe;
      logic [7:0]  prevDefLed;
      logic [7:0]  defLeds[$];
      int          holdCnt;
      bit          anyReset;
      bit          checkRestart;
      int          resetAt;
      logic [7:0]  prevLed;
      logic [26:0] srwLog[$];
      int          srwCyc[$];
      logic [7:0]  ledLog[$];

      rstN    = 1'b0;
      rstDefN = 1'b0;
      repeat (3) @(negedge clk);

      checkVal("rst_led",  32'(led),       32'd0);
      checkVal("rst_addr", 32'(sramAddr),  32'd0);
      checkVal("rst_data", 32'(sramData),  32'd0);
      checkVal("rst_ce",   32'(ce),        32'd1);
      checkVal("rst_we",   32'(we),        32'd1);
      checkVal("rst_oe",   32'(oe),        32'd1);
      checkVal("rst_pc",   32'(dut.pcReg), 32'd0);
      checkVal("def_rst_led", 32'(defLed), 32'd0);
      checkVal("def_rst_ce",  32'(defCe),  32'd1);

      // Default program.
      rstDefN    = 1'b1;
      prevDefCe  = 1'b1;
      prevDefLed = 8'd0;
      defCount   = 0;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         checkVal("def_oe", 32'(defOe), 32'd1);
         if (!defCe) begin
            defCount++;
            checkVal("def_pulse_width", 32'(prevDefCe), 32'd1);
            checkVal("def_we",   32'(defWe),   32'd0);
            checkVal("def_addr", 32'(defAddr), 32'(defCount));
            checkVal("def_data", 32'(defData), 32'(defCount % 256));
            $display("[TB] default SRAM write %0d: addr=%0h data=%0h", defCount, defAddr, defData);
         end else begin
            checkVal("def_we_idle", 32'(defWe), 32'd1);
         end
         if (defLed != prevDefLed) begin
            defLeds.push_back(defLed);
            $display("[TB] default LED -> %0d", defLed);
         end
         prevDefLed = defLed;
         prevDefCe  = defCe;
      end
      checkVal("def_srw_count", 32'(defCount), 32'd11);
      checkVal("def_led_steps", 32'(defLeds.size()), 32'd11);
      for (int i = 0; i < defLeds.size() && i < 11; i++) begin
         checkVal("def_led_value", 32'(defLeds[i]), 32'(i + 1));
      end
      checkVal("def_led_hold", 32'(defLed), 32'd11);

      // Test image in lockstep with the model, random reset pulses.
      m            = '0;
      m.ce         = 1'b1;
      rstN         = 1'b1;
      prevLed      = 8'd0;
      anyReset     = 1'b0;
      checkRestart = 1'b0;
      holdCnt      = 0;
      resetAt      = 250 + int'($urandom_range(0, 40));
      for (int c = 0; c < 600; c++) begin
         @(posedge clk);
         if (rstN) m = stepModel(m, IMG[int'(m.pc)*24 +: 24]);
         @(negedge clk);
         compareModel();
         if (checkRestart) begin
            checkVal("restart_pc", 32'(dut.pcReg), 32'd1);
            checkRestart = 1'b0;
         end
         if (!anyReset) begin
            if (!ce) begin
               srwLog.push_back({sramAddr, sramData});
               srwCyc.push_back(c);
            end
            if (led != prevLed) ledLog.push_back(led);
         end
         if (!ce) $display("[TB] cycle %0d SRAM write addr=%0h data=%0h", c, sramAddr, sramData);
         prevLed = led;
         if (!rstN) begin
            holdCnt--;
            if (holdCnt == 0) begin
               rstN         = 1'b1;
               checkRestart = 1'b1;
            end
         end else if (c == resetAt || (c > 300 && $urandom_range(0, 49) == 0)) begin
            #2 rstN = 1'b0;
            #1;
            checkVal("async_rst_led",  32'(led),       32'd0);
            checkVal("async_rst_addr", 32'(sramAddr),  32'd0);
            checkVal("async_rst_data", 32'(sramData),  32'd0);
            checkVal("async_rst_ce",   32'(ce),        32'd1);
            checkVal("async_rst_we",   32'(we),        32'd1);
            checkVal("async_rst_pc",   32'(dut.pcReg), 32'd0);
            $display("[TB] cycle %0d reset asserted mid-run", c);
            m        = '0;
            m.ce     = 1'b1;
            anyReset = 1'b1;
            holdCnt  = int'($urandom_range(1, 3));
         end
      end

      // Spec-level values from the first pass of the image.
      checkVal("first_srw_seen", 32'(srwLog.size() >= 4), 32'd1);
      if (srwLog.size() >= 4) begin
         checkVal("add_wrap",         32'(srwLog[0]), 32'({19'h00000, 8'h00}));
         checkVal("sub_borrow",       32'(srwLog[1]), 32'({19'h0FFFF, 8'hFF}));
         checkVal("smul_signed",      32'(srwLog[2]), 32'({19'h0FFFA, 8'hFA}));
         checkVal("srw_b2b_second",   32'(srwLog[3]), 32'({19'h0FFFF, 8'h01}));
         checkVal("srw_b2b_adjacent", 32'(srwCyc[3] - srwCyc[2]), 32'd1);
      end
      checkVal("first_led_seen", 32'(ledLog.size() >= 3), 32'd1);
      if (ledLog.size() >= 3) begin
         checkVal("ble_taken",     32'(ledLog[0]), 32'd5);
         checkVal("ble_not_taken", 32'(ledLog[1]), 32'd6);
         checkVal("ble_unsigned",  32'(ledLog[2]), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
